// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multi-cycle RISC-V datapath that shares one ALU for
//   PC+4, effective address, branch target and execute. Supports lw, sw,
//   R-type, I-type ALU, beq, blt and jal.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   opcode/funct3/funct7b5 instruction fields from the instruction register
//   zero, signbit         ALU result flags used for branch resolution
//   mem_ready             memory access completes this cycle
//   alu_sel               ALU operation select
//   alu_src_a/alu_src_b   ALU operand muxes
//   imm_src               immediate format (from opcode)
//   result_src, adr_src   result and memory-address muxes
//   ir_write, pc_write, reg_write, mem_write, mem_req   enables
//   illegal               one-cycle pulse on unsupported opcode/funct3
module multicycle_ctrl #(
    parameter logic [2:0] ALU_ADD = 3'd3,
    parameter logic [2:0] ALU_SUB = 3'd6,
    parameter logic [2:0] ALU_AND = 3'd0,
    parameter logic [2:0] ALU_OR  = 3'd1,
    parameter logic [2:0] ALU_SLL = 3'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       signbit,
    input  logic       mem_ready,
    output logic [2:0] alu_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_req,
    output logic       illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    state_t state_q, state_d;

    // ALU function decode shared by EXECR/EXECI. funct7b5 selects SUB only
    // for R-type; I-type has no subtract so bit 30 is part of the immediate.
    logic [2:0] funct_sel;
    logic       funct_ok;

    always_comb begin
        funct_sel = ALU_AND;
        funct_ok  = 1'b1;
        case (funct3)
            3'b000:  funct_sel = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  funct_sel = ALU_AND;
            3'b110:  funct_sel = ALU_OR;
            3'b001:  funct_sel = ALU_SLL;
            default: funct_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = funct_ok ? S_ALUWB : S_FETCH;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode. Mostly Moore; the fetch handshake, branch resolution
    // and illegal detection also look at the current inputs.
    always_comb begin
        alu_sel    = 3'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        imm_src    = 3'd0;
        result_src = 2'd0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        illegal    = 1'b0;

        // Immediate format follows the opcode; held at 0 in IDLE so the
        // post-reset state is fully quiet.
        if (state_q != S_IDLE) begin
            case (opcode)
                OP_SW:   imm_src = 3'd1;
                OP_BR:   imm_src = 3'd2;
                OP_JAL:  imm_src = 3'd3;
                default: imm_src = 3'd0;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                // PC+4 is computed and written in the same cycle the
                // instruction arrives, so nothing is committed while waiting.
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = 2'd0;
                    alu_src_b  = 2'd2;
                    alu_sel    = ALU_ADD;
                    result_src = 2'd2;
                end
            end
            S_DECODE: begin
                // oldPC + imm: branch target sits in ALUOut for BRANCH.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_sel   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL: illegal = 1'b0;
                    default:                                 illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_sel   = ALU_ADD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = 2'd2;
                alu_src_b = (state_q == S_EXECI) ? 2'd1 : 2'd0;
                alu_sel   = funct_ok ? funct_sel : 3'd0;
                illegal   = ~funct_ok;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                // rs1 - rs2; target from DECODE is still in ALUOut.
                alu_src_a = 2'd2;
                alu_src_b = 2'd0;
                alu_sel   = ALU_SUB;
                case (funct3)
                    3'b000:  pc_write = zero;
                    3'b100:  pc_write = signbit;
                    default: illegal  = 1'b1;
                endcase
            end
            S_JAL: begin
                // Link value oldPC+4 goes to ALUOut; PC takes the target
                // computed in DECODE.
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_sel   = ALU_ADD;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, zero, signbit, mem_ready;
    logic [2:0] alu_sel, imm_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       adr_src, ir_write, pc_write, reg_write, mem_write, mem_req, illegal;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .signbit(signbit),
        .mem_ready(mem_ready), .alu_sel(alu_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .mem_write(mem_write), .mem_req(mem_req),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Output bundle: sel,a,b,imm,res,adr,ir,pc,rw,mw,mr,ill
    logic [18:0] outs;
    assign outs = {alu_sel, alu_src_a, alu_src_b, imm_src, result_src,
                   adr_src, ir_write, pc_write, reg_write, mem_write, mem_req, illegal};

    function automatic logic [18:0] o(input int sel, a, b, imm, res, adr,
                                      ir, pc, rw, mw, mr, ill);
        o = {sel[2:0], a[1:0], b[1:0], imm[2:0], res[1:0],
             adr[0], ir[0], pc[0], rw[0], mw[0], mr[0], ill[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [18:0] exp);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        zero = 1'b0; signbit = 1'b0; mem_ready = 1'b1;

        // Reset / first fetch
        tick();                        chk("reset_idle", '0);
        rst = 1'b0; #1;                chk("idle_release", '0);
        tick();                        chk("fetch_r", o(3,0,2,0,2,0,1,1,0,0,1,0));

        // R-type SUB
        tick();                        chk("decode_r", o(3,1,1,0,0,0,0,0,0,0,0,0));
        tick();                        chk("execr_sub", o(6,2,0,0,0,0,0,0,0,0,0,0));
        tick();                        chk("aluwb_r", o(0,0,0,0,0,0,0,0,1,0,0,0));
        tick();
        // R-type AND
        funct3 = 3'b111; funct7b5 = 1'b0;
        tick(); tick();                chk("execr_and", o(0,2,0,0,0,0,0,0,0,0,0,0));
        tick(); tick();

        // lw with three wait cycles in MEMREAD
        opcode = 7'b0000011; funct3 = 3'b010;
        tick();                        chk("decode_lw", o(3,1,1,0,0,0,0,0,0,0,0,0));
        tick();                        chk("memadr_lw", o(3,2,1,0,0,0,0,0,0,0,0,0));
        mem_ready = 1'b0;
        tick();                        chk("memread_w1", o(0,0,0,0,0,1,0,0,0,0,1,0));
        tick();                        chk("memread_w2", o(0,0,0,0,0,1,0,0,0,0,1,0));
        tick();                        chk("memread_w3", o(0,0,0,0,0,1,0,0,0,0,1,0));
        mem_ready = 1'b1; #1;          chk("memread_done", o(0,0,0,0,0,1,0,0,0,0,1,0));
        tick();                        chk("memwb", o(0,0,0,0,1,0,0,0,1,0,0,0));

        // sw
        opcode = 7'b0100011;
        tick();                        chk("fetch_sw", o(3,0,2,1,2,0,1,1,0,0,1,0));
        tick(); tick();
        tick();                        chk("memwrite", o(0,0,0,1,0,1,0,0,0,1,1,0));
        tick();                        chk("fetch_after_sw", o(3,0,2,1,2,0,1,1,0,0,1,0));

        // beq taken
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        tick(); tick();                chk("beq_taken", o(6,2,0,2,0,0,0,1,0,0,0,0));
        tick();
        // blt: signbit drives pc_write, not zero
        funct3 = 3'b100; signbit = 1'b0;
        tick(); tick();                chk("blt_not_taken", o(6,2,0,2,0,0,0,0,0,0,0,0));
        signbit = 1'b1; #1;            chk("blt_taken", o(6,2,0,2,0,0,0,1,0,0,0,0));
        // unsupported branch funct3
        tick(); funct3 = 3'b001;
        tick(); tick();                chk("branch_illegal", o(6,2,0,2,0,0,0,0,0,0,0,1));
        tick();

        // jal
        opcode = 7'b1101111; zero = 1'b0; signbit = 1'b0;
        tick(); tick();                chk("jal", o(3,1,2,3,0,0,0,1,0,0,0,0));
        tick();                        chk("jal_aluwb", o(0,0,0,3,0,0,0,0,1,0,0,0));
        tick();

        // illegal opcode
        opcode = 7'b0000000;
        tick();                        chk("decode_illegal", o(3,1,1,0,0,0,0,0,0,0,0,1));
        tick();                        chk("fetch_after_ill", o(3,0,2,0,2,0,1,1,0,0,1,0));

        // I-type: funct7b5 ignored, ADD
        opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick();                chk("execi_add", o(3,2,1,0,0,0,0,0,0,0,0,0));
        tick(); tick();
        // I-type illegal funct3
        funct3 = 3'b010;
        tick(); tick();                chk("execi_illegal", o(0,2,1,0,0,0,0,0,0,0,0,1));
        tick();                        chk("fetch_no_wb", o(3,0,2,0,2,0,1,1,0,0,1,0));

        // Reset while waiting in MEMREAD
        opcode = 7'b0000011;
        tick(); tick();
        mem_ready = 1'b0;
        tick();                        chk("memread_pre_rst", o(0,0,0,0,0,1,0,0,0,0,1,0));
        rst = 1'b1;
        tick();                        chk("rst_midwait", '0);
        mem_ready = 1'b1;
        tick();                        chk("rst_hold", '0);
        rst = 1'b0;
        tick();                        chk("fetch_after_rst", o(3,0,2,0,2,0,1,1,0,0,1,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle RISC-V control FSM; the issuing end of the ALU interface.
- Drives the 3-bit ALU operation select, operand muxes and register/memory/PC write enables for a multi-cycle datapath that reuses one ALU for PC+4, address, branch-target and execute computations.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, blt, jal.

Parameters:
- ALU_ADD, 3, select code for inp1+inp2
- ALU_SUB, 6, select code for inp1-inp2
- ALU_AND, 0, select code for AND
- ALU_OR, 1, select code for OR
- ALU_SLL, 4, select code for inp1<<inp2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  datapath ALU-result==0 flag
- signbit  in  1  ALU result bit 31
- mem_ready  in  1  memory access completes this cycle
- alu_sel  out  3  ALU operation select
- alu_src_a  out  2  0=PC, 1=oldPC, 2=rs1
- alu_src_b  out  2  0=rs2, 1=imm, 2=const 4
- imm_src  out  3  0=I, 1=S, 2=B, 3=J
- result_src  out  2  0=ALUOut reg, 1=mem data, 2=ALU result
- adr_src  out  1  0=PC, 1=result
- ir_write, pc_write, reg_write, mem_write, mem_req  out  1 each  enables
- illegal  out  1  one-cycle pulse on unsupported opcode/funct3

Behaviour:
- Moore outputs decoded from state; imm_src decoded from opcode.
- Any output not listed for a state is 0. mem_req defaults to 0.
- States and actions:
  - IDLE: all outputs 0 → FETCH.
  - FETCH: mem_req=1, adr_src=0. Holds while mem_ready=0. In the cycle mem_ready=1: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=2, alu_sel=ADD, result_src=2 → DECODE. ir_write/pc_write only in that cycle.
  - DECODE: alu_src_a=1, alu_src_b=1, alu_sel=ADD (branch target latched). Next state by opcode:
    - 0000011/0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - else illegal=1 → FETCH
  - MEMADR: alu_src_a=2, alu_src_b=1, ADD → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: mem_req=1, adr_src=1, result_src=0. Hold until mem_ready → MEMWB.
  - MEMWB: result_src=1, reg_write=1 → FETCH.
  - MEMWRITE: mem_req=1, adr_src=1, result_src=0, mem_write=1. Hold until mem_ready → FETCH.
  - EXECR/EXECI: alu_src_a=2, alu_src_b=0 (R) or 1 (I), alu_sel from funct decode. Legal → ALUWB; illegal funct3 → illegal=1 → FETCH, no writeback.
  - ALUWB: result_src=0, reg_write=1 → FETCH.
  - BRANCH: alu_src_a=2, alu_src_b=0, alu_sel=SUB, result_src=0.
    - funct3=000: pc_write=zero.
    - funct3=100: pc_write=signbit.
    - Other funct3: illegal=1, pc_write=0.
    - → FETCH.
  - JAL: alu_src_a=1, alu_src_b=2, ADD, result_src=0, pc_write=1 → ALUWB.
- Funct decode:
  - 000 → ADD, except R-type with funct7b5=1 → SUB (I-type ignores funct7b5).
  - 111 → AND; 110 → OR; 001 → SLL.
  - Others illegal.
- Reset: rst=1 at any clock edge, including mid-wait in FETCH/MEMREAD/MEMWRITE, forces IDLE next cycle, all outputs 0. mem_ready is ignored outside wait states.
- Latency, mem_ready=1 immediately:
  - R/I: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles

Test Plan:
- Reset then release, mem_ready=1 → cycle 1 IDLE, all outputs 0; cycle 2 FETCH with ir_write=pc_write=1, alu_sel=3, alu_src_b=2.
- R-type opcode 0110011, funct3=000, funct7b5=1 → EXECR alu_sel=6 → ALUWB reg_write=1 → FETCH; funct3=111 gives alu_sel=0.
- lw with mem_ready low 3 cycles in MEMREAD → mem_req held 4 cycles, then MEMWB result_src=1, reg_write=1; sw → mem_write=1 only in MEMWRITE.
- beq: zero=1 → pc_write=1. blt: signbit=0 → pc_write=0. Both with alu_sel=6.
- opcode 0000000 → illegal pulse in DECODE, no enables, back to FETCH; I-type funct3=010 → illegal in EXECI, no reg_write.
- rst asserted while waiting in MEMREAD → next cycle IDLE, mem_req=0, no reg_write issued.
